// File: rtl/des_key_sched_ctrl.sv
// DES key schedule controller: PC-1 load, per-round C/D rotation and
// registered PC-2 subkey output with valid/ready handshakes.
module des_key_sched_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [1:64] key_i,
    input  logic        decrypt_i,
    input  logic        abort_i,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic [1:48] subkey_o,
    output logic [3:0]  round_o,
    output logic        last_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:28] c;
    logic [1:28] c_nxt;
    logic [1:28] d;
    logic [1:28] d_nxt;
    logic [3:0]  round;
    logic [3:0]  round_nxt;
    logic        dec;
    logic        dec_nxt;
    logic        two;
    logic [1:56] pc1;
    logic [1:56] cd;
    logic        parity_unused;

    function automatic logic [1:28] rot_l(input logic [1:28] x,
                                          input logic two_step);
        rot_l = two_step ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rot_r(input logic [1:28] x,
                                          input logic two_step);
        rot_r = two_step ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    assign pc1 = {
        key_i[57], key_i[49], key_i[41], key_i[33],
        key_i[25], key_i[17], key_i[9],
        key_i[1],  key_i[58], key_i[50], key_i[42],
        key_i[34], key_i[26], key_i[18],
        key_i[10], key_i[2],  key_i[59], key_i[51],
        key_i[43], key_i[35], key_i[27],
        key_i[19], key_i[11], key_i[3],  key_i[60],
        key_i[52], key_i[44], key_i[36],
        key_i[63], key_i[55], key_i[47], key_i[39],
        key_i[31], key_i[23], key_i[15],
        key_i[7],  key_i[62], key_i[54], key_i[46],
        key_i[38], key_i[30], key_i[22],
        key_i[14], key_i[6],  key_i[61], key_i[53],
        key_i[45], key_i[37], key_i[29],
        key_i[21], key_i[13], key_i[5],  key_i[28],
        key_i[20], key_i[12], key_i[4]
    };

    // Parity bits take no part in the schedule.
    assign parity_unused = ^{key_i[8],  key_i[16], key_i[24], key_i[32],
                             key_i[40], key_i[48], key_i[56], key_i[64]};

    assign cd = {c, d};

    assign subkey_o = {
        cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
        cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
        cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
        cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
        cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
        cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
        cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
        cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]
    };

    assign key_ready_o    = (state == IDLE) && !abort_i;
    assign subkey_valid_o = (state == OUT);
    assign last_o         = (state == OUT) && (round == LAST);
    assign busy_o         = (state != IDLE);
    assign round_o        = round;

    // Encrypt rotates by s[round+1]; decrypt undoes s[17-round].
    // Single-step rounds are s index 1, 2, 9 and 16.
    always_comb begin
        two = 1'b1;
        if (dec) begin
            if (round inside {4'd1, 4'd8, 4'd15}) two = 1'b0;
        end else begin
            if (round inside {4'd0, 4'd1, 4'd8, 4'd15}) two = 1'b0;
        end
    end

    // Next-state and datapath update; abort overrides every handshake.
    always_comb begin
        state_nxt = state;
        c_nxt     = c;
        d_nxt     = d;
        round_nxt = round;
        dec_nxt   = dec;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_valid_i) begin
                        state_nxt = ROT;
                        c_nxt     = pc1[1:28];
                        d_nxt     = pc1[29:56];
                        dec_nxt   = decrypt_i;
                        round_nxt = 4'd0;
                    end
                end
                ROT: begin
                    state_nxt = OUT;
                    if (!dec) begin
                        c_nxt = rot_l(c, two);
                        d_nxt = rot_l(d, two);
                    end else if (round != 4'd0) begin
                        c_nxt = rot_r(c, two);
                        d_nxt = rot_r(d, two);
                    end
                end
                OUT: begin
                    if (subkey_ready_i) begin
                        if (round == LAST) begin
                            state_nxt = IDLE;
                        end else begin
                            round_nxt = round + 4'd1;
                            state_nxt = ROT;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and C/D/round/direction registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            c     <= '0;
            d     <= '0;
            round <= '0;
            dec   <= 1'b0;
        end else begin
            state <= state_nxt;
            c     <= c_nxt;
            d     <= d_nxt;
            round <= round_nxt;
            dec   <= dec_nxt;
        end
    end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl using the classic
// 0x133457799BBCDFF1 key and its hand-derived subkeys.
module tb_des_key_sched_ctrl;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [1:64] key;
    logic        decrypt;
    logic        abort;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [1:48] subkey;
    logic [3:0]  round;
    logic        last;
    logic        busy;

    logic        s_key_valid;
    logic        s_key_ready;
    logic [1:64] s_key;
    logic        s_decrypt;
    logic        s_abort;
    logic        s_valid;
    logic        s_ready;
    logic [1:48] s_subkey;
    logic [3:0]  s_round;
    logic        s_last;
    logic        s_busy;

    int tests = 0;
    int fails = 0;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    logic [47:0] ke [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5,
        48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F,
        48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F,
        48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A,
        48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_sched_ctrl #(.ROUNDS(16)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .key_valid_i    (key_valid),
        .key_ready_o    (key_ready),
        .key_i          (key),
        .decrypt_i      (decrypt),
        .abort_i        (abort),
        .subkey_valid_o (subkey_valid),
        .subkey_ready_i (subkey_ready),
        .subkey_o       (subkey),
        .round_o        (round),
        .last_o         (last),
        .busy_o         (busy)
    );

    des_key_sched_ctrl #(.ROUNDS(1)) dut1 (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .key_valid_i    (s_key_valid),
        .key_ready_o    (s_key_ready),
        .key_i          (s_key),
        .decrypt_i      (s_decrypt),
        .abort_i        (s_abort),
        .subkey_valid_o (s_valid),
        .subkey_ready_i (s_ready),
        .subkey_o       (s_subkey),
        .round_o        (s_round),
        .last_o         (s_last),
        .busy_o         (s_busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, subkey_valid, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_round"}, round, 0);
        check({tag, "_subkey"}, subkey, 0);
        check({tag, "_kready"}, key_ready, 1);
    endtask

    // Offer a key at a negedge in IDLE, then collect all 16 subkeys.
    task automatic run_sched(input logic [63:0] k, input logic dec,
                             input logic bp);
        int          hs;
        int          cyc;
        logic        stalled;
        logic        rdy;
        logic [47:0] sv_key;
        logic [3:0]  sv_round;
        logic        sv_last;
        logic [47:0] exp;
        key_valid    = 1'b1;
        key          = k;
        decrypt      = dec;
        subkey_ready = 1'b0;
        #1;
        check("accept_ready", key_ready, 1);
        @(negedge clk);
        key_valid = 1'b0;
        key       = ~k;
        decrypt   = ~dec;
        hs        = 0;
        cyc       = 0;
        stalled   = 1'b0;
        sv_key    = '0;
        sv_round  = '0;
        sv_last   = 1'b0;
        while (hs < 16 && cyc < 200) begin
            if (stalled) begin
                check("hold_valid", subkey_valid, 1);
                check("hold_subkey", subkey, sv_key);
                check("hold_round", round, sv_round);
                check("hold_last", last, sv_last);
            end
            if (subkey_valid) begin
                if (hs == 0 && !stalled) check("latency", cyc, 1);
                rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                subkey_ready = rdy;
                if (rdy) begin
                    exp = dec ? ke[15 - hs] : ke[hs];
                    check("subkey", subkey, exp);
                    check("round", round, hs);
                    check("last", last, (hs == 15) ? 1 : 0);
                    hs++;
                    stalled = 1'b0;
                end else begin
                    sv_key   = subkey;
                    sv_round = round;
                    sv_last  = last;
                    stalled  = 1'b1;
                end
            end else begin
                subkey_ready = 1'b0;
                stalled      = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        subkey_ready = 1'b0;
        check("handshakes", hs, 16);
        check("end_busy", busy, 0);
        check("end_valid", subkey_valid, 0);
    endtask

    // Start a key and step until subkey of round r is on the output.
    task automatic reach_round(input logic [3:0] r);
        int cyc;
        key_valid    = 1'b1;
        key          = KEY;
        decrypt      = 1'b0;
        subkey_ready = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        cyc = 0;
        while (!(subkey_valid && round == r) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_round", round, r);
    endtask

    initial begin
        rst_n        = 1'b0;
        key_valid    = 1'b0;
        key          = '0;
        decrypt      = 1'b0;
        abort        = 1'b0;
        subkey_ready = 1'b0;
        s_key_valid  = 1'b0;
        s_key        = '0;
        s_decrypt    = 1'b0;
        s_abort      = 1'b0;
        s_ready      = 1'b0;

        #3;
        check_reset_outputs("rst");
        abort = 1'b1;
        #1;
        check("rst_abort_kready", key_ready, 0);
        abort = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_sched(KEY, 1'b0, 1'b0);
        run_sched(KEY, 1'b1, 1'b0);
        run_sched(KEY, 1'b0, 1'b1);

        reach_round(4'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        subkey_ready = 1'b0;
        check("abort_valid", subkey_valid, 0);
        check("abort_busy", busy, 0);
        #1;
        check("abort_kready", key_ready, 1);
        @(negedge clk);
        run_sched(KEY, 1'b0, 1'b0);

        reach_round(4'd8);
        @(negedge clk);
        check("rot9_busy", busy, 1);
        check("rot9_valid", subkey_valid, 0);
        check("rot9_round", round, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check("midrst_hold_valid", subkey_valid, 0);
        rst_n = 1'b1;
        subkey_ready = 1'b0;
        @(negedge clk);
        check("post_rst_valid", subkey_valid, 0);
        check("post_rst_busy", busy, 0);
        run_sched(KEY, 1'b0, 1'b0);

        s_key_valid = 1'b1;
        s_key       = KEY;
        s_decrypt   = 1'b0;
        s_ready     = 1'b1;
        #1;
        check("r1_kready0", s_key_ready, 1);
        @(negedge clk);
        check("r1_busy1", s_busy, 1);
        check("r1_kready1", s_key_ready, 0);
        check("r1_valid1", s_valid, 0);
        @(negedge clk);
        check("r1_valid2", s_valid, 1);
        check("r1_subkey2", s_subkey, ke[0]);
        check("r1_last2", s_last, 1);
        check("r1_round2", s_round, 0);
        check("r1_kready2", s_key_ready, 0);
        s_decrypt = 1'b1;
        @(negedge clk);
        check("r1_busy3", s_busy, 0);
        check("r1_kready3", s_key_ready, 1);
        check("r1_valid3", s_valid, 0);
        @(negedge clk);
        check("r1_busy4", s_busy, 1);
        @(negedge clk);
        check("r1_valid5", s_valid, 1);
        check("r1_subkey5", s_subkey, ke[15]);
        check("r1_last5", s_last, 1);
        s_key_valid = 1'b0;
        @(negedge clk);
        check("r1_busy6", s_busy, 0);
        @(negedge clk);
        check("r1_busy7", s_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/des_key_sched_ctrl.md
DES_KEY_SCHED_CTRL -- requirements
Module: des_key_sched_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 16, giving the number of subkeys produced per key; legal range 1..16.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port key_valid_i, input, 1 bit: a 64-bit key is offered.
REQ-005 SHALL have port key_ready_o, output, 1 bit: the controller can accept a key.
REQ-006 SHALL have port key_i, input, [1:64]: DES key, bit 1 = MSB; parity bits 8,16,...,64 are ignored.
REQ-007 SHALL have port decrypt_i, input, 1 bit: sampled with the key; 1 = emit subkeys in order K16..K1.
REQ-008 SHALL have port abort_i, input, 1 bit: synchronous cancel of the current schedule.
REQ-009 SHALL have port subkey_valid_o, output, 1 bit: subkey_o is valid.
REQ-010 SHALL have port subkey_ready_i, input, 1 bit: the consumer takes subkey_o.
REQ-011 SHALL have port subkey_o, output, [1:48]: PC-2 of the current C||D, bit 1 = MSB.
REQ-012 SHALL have port round_o, output, [3:0]: 0-based index of the subkey on subkey_o.
REQ-013 SHALL have port last_o, output, 1 bit: high with subkey_valid_o when round_o == ROUNDS-1.
REQ-014 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ROT, OUT.
REQ-016 SHALL drive key_ready_o = (state==IDLE) && !abort_i.
REQ-017 SHALL, on key handshake (key_valid_i && key_ready_o), load C = PC-1 bits 1..28 and D = PC-1 bits 29..56, latch decrypt_i, clear round to 0, and enter ROT.
REQ-018 SHALL use the shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-019 SHALL, in ROT for encrypt, rotate C and D left by s[round+1] as 28-bit circular rotates, then enter OUT; ROT lasts exactly one cycle.
REQ-020 SHALL, in ROT for decrypt, apply no rotation when round==0; otherwise rotate C and D right by s[17-round]; then enter OUT.
REQ-021 SHALL drive subkey_o = PC-2(C||D) from registered C and D, with no combinational path from any input to subkey_o.
REQ-022 SHALL assert subkey_valid_o only in OUT, and hold subkey_o, round_o and last_o stable until the subkey handshake.
REQ-023 SHALL, on subkey handshake in OUT, enter IDLE if round==ROUNDS-1; otherwise increment round and enter ROT.
REQ-024 SHALL give a latency of 2 cycles from key handshake to the first subkey_valid_o, and a peak rate of one subkey per 2 cycles.
REQ-025 SHALL give abort_i priority over all handshakes: from any state the next state is IDLE, subkey_valid_o deasserts the next cycle, and no subkey handshake is counted that cycle.
REQ-026 SHALL ignore key_valid_i outside IDLE, and SHALL ignore changes on key_i and decrypt_i after acceptance.
REQ-027 SHALL permit back-to-back keys: a new key may be accepted in the first IDLE cycle after the last subkey handshake.

Reset
REQ-028 SHALL, while rst_n_i is low, force state=IDLE, C=D=0, round=0, and decrypt latch=0.
REQ-029 SHALL, during reset, drive subkey_valid_o=0, last_o=0, busy_o=0, round_o=0, subkey_o=PC-2(0)=0, and key_ready_o=!abort_i.
REQ-030 SHALL, when reset is asserted mid-schedule, abandon the schedule immediately; no further subkey from that key is ever emitted.

Verification
REQ-031 SHALL be verified by: key 0x133457799BBCDFF1, encrypt, subkey_ready_i=1 -> first valid 2 cycles after accept, subkey_o=0x1B02EFFC7072 with round_o=0, 16th subkey=0xCB3D8B0E17F5 with last_o=1, then IDLE.
REQ-032 SHALL be verified by: same key, decrypt -> round_o=0 gives 0xCB3D8B0E17F5, round_o=15 gives 0x1B02EFFC7072; all 16 subkeys equal the encrypt list reversed.
REQ-033 SHALL be verified by: random subkey_ready_i backpressure (~50%) -> subkey_o, round_o and last_o never change while valid && !ready; exactly 16 handshakes occur; the sequence matches the reference model.
REQ-034 SHALL be verified by: abort_i pulse in OUT at round 5 -> subkey_valid_o=0 the next cycle, busy_o=0, key_ready_o=1; a new key then yields the correct K1.
REQ-035 SHALL be verified by: rst_n_i low mid-ROT at round 9 -> all outputs reach reset values asynchronously; after release, the first subkey of a new key is correct.
REQ-036 SHALL be verified by: ROUNDS=1 build, plus key_valid_i held high continuously -> one subkey with last_o=1, the next key accepted in the first IDLE cycle, and no key accepted while busy_o=1.
